sobel_row_loader: RTL and testbench

SOBEL_ROW_LOADER -- requirements
Module: sobel_row_loader

---
 rtl/sobel_pkg.sv | 21 ++
 rtl/sobel_row_loader_if.sv | 31 +++
 rtl/sobel_row_loader_row_buffer.sv | 40 ++++
 rtl/sobel_row_loader.sv | 160 ++++++++++++++++
 tb/tb_sobel_row_loader.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/sobel_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sobel_pkg
// Description : Pixel type and width shared by the row loader and the Sobel
//               stages, plus a counter-width helper.
// Revision    : 1.0 - initial release
// ============================================================================
package sobel_pkg;

    localparam int PIX_W = 8;

    typedef logic [PIX_W-1:0] pixel_t;

    // Width of a counter that must reach n-1; never zero so a degenerate
    // parameter still yields a legal vector.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage : sobel_pkg
`default_nettype wire

// File: rtl/sobel_row_loader_if.sv
`default_nettype none
// ============================================================================
// Module      : sobel_row_loader_if
// Description : Raster pixel stream with valid/ready handshake and a
//               start-of-frame marker.
// Revision    : 1.0 - initial release
// ============================================================================
interface sobel_row_loader_if;
    import sobel_pkg::*;

    pixel_t pix_in;
    logic   pix_valid;
    logic   pix_sof;
    logic   pix_ready;

    modport master (
        output pix_in,
        output pix_valid,
        output pix_sof,
        input  pix_ready
    );

    modport slave (
        input  pix_in,
        input  pix_valid,
        input  pix_sof,
        output pix_ready
    );

endinterface : sobel_row_loader_if
`default_nettype wire

// File: rtl/sobel_row_loader_row_buffer.sv
`default_nettype none
// ============================================================================
// Module      : row_buffer
// Description : SIZE x 8 register file, one addressed write port and a
//               parallel read port exposing every entry.
// Revision    : 1.0 - initial release
// ============================================================================
module row_buffer
    import sobel_pkg::*;
#(
    parameter int SIZE = 100,
    parameter int AW   = cnt_w(SIZE)
) (
    input  wire logic           clk,
    input  wire logic           rst_n,
    input  wire logic           we_i,
    input  wire logic [AW-1:0]  waddr_i,
    input  wire pixel_t         wdata_i,
    output pixel_t              rdata_o [SIZE-1:0]
);

    pixel_t mem_q [SIZE-1:0];

    // One decoded write enable per entry keeps out-of-range addresses harmless.
    generate
        for (genvar gi = 0; gi < SIZE; gi++) begin : g_entry
            // Capture the write data into this entry when addressed.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    mem_q[gi] <= '0;
                end else if (we_i && (waddr_i == AW'(gi))) begin
                    mem_q[gi] <= wdata_i;
                end
            end
            assign rdata_o[gi] = mem_q[gi];
        end
    endgenerate

endmodule : row_buffer
`default_nettype wire

// File: rtl/sobel_row_loader.sv
`default_nettype none
// ============================================================================
// Module      : sobel_row_loader
// Description : Collects a raster pixel stream into rows of SIZE pixels and
//               presents each completed row in parallel to the Sobel array.
// Revision    : 1.0 - initial release
// ============================================================================
module sobel_row_loader
    import sobel_pkg::*;
#(
    parameter int SIZE = 100,
    parameter int ROWS = 100
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    sobel_row_loader_if.slave  pix_if,
    output pixel_t             arr_out [SIZE-1:0],
    output logic               row_valid,
    output logic               row_last,
    output logic               sof_err
);

    localparam int c_COL_W = cnt_w(SIZE);
    localparam int c_ROW_W = cnt_w(ROWS);
    localparam logic [c_COL_W-1:0] c_COL_LAST = c_COL_W'(SIZE - 1);
    localparam logic [c_ROW_W-1:0] c_ROW_LAST = c_ROW_W'(ROWS - 1);

    typedef enum logic [0:0] {
        WAIT_SOF = 1'b0,
        FILL     = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [c_COL_W-1:0]   col_q,   col_d;
    logic [c_ROW_W-1:0]   row_q,   row_d;
    logic                 row_valid_q, row_valid_d;
    logic                 row_last_q,  row_last_d;
    logic                 sof_err_q,   sof_err_d;
    pixel_t               arr_q [SIZE-1:0];

    logic                 accept;
    logic                 buf_we;
    logic [c_COL_W-1:0]   buf_waddr;
    logic                 arr_load;
    pixel_t               buf_rd [SIZE-1:0];

    // The loader never back-pressures; it is only unready while held in reset.
    assign pix_if.pix_ready = rst_n;
    assign accept           = pix_if.pix_valid && pix_if.pix_ready;

    row_buffer #(
        .SIZE (SIZE),
        .AW   (c_COL_W)
    ) u_row_buffer (
        .clk     (clk),
        .rst_n   (rst_n),
        .we_i    (buf_we),
        .waddr_i (buf_waddr),
        .wdata_i (pix_if.pix_in),
        .rdata_o (buf_rd)
    );

    // Next-state, counter and buffer-write decisions for each accepted pixel.
    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        row_d       = row_q;
        sof_err_d   = sof_err_q;
        row_valid_d = 1'b0;
        row_last_d  = 1'b0;
        buf_we      = 1'b0;
        buf_waddr   = col_q;
        arr_load    = 1'b0;

        unique case (state_q)
            WAIT_SOF: begin
                if (accept && pix_if.pix_sof) begin
                    buf_we    = 1'b1;
                    buf_waddr = '0;
                    col_d     = c_COL_W'(1);
                    row_d     = '0;
                    state_d   = FILL;
                end
            end
            FILL: begin
                if (accept) begin
                    if (pix_if.pix_sof) begin
                        // Frame restart; only a restart mid-row is an error,
                        // including one on the pixel that would finish a row.
                        if (col_q != '0) begin
                            sof_err_d = 1'b1;
                        end
                        buf_we    = 1'b1;
                        buf_waddr = '0;
                        col_d     = c_COL_W'(1);
                        row_d     = '0;
                    end else if (col_q == c_COL_LAST) begin
                        // Last pixel bypasses the buffer straight into arr_out.
                        arr_load    = 1'b1;
                        col_d       = '0;
                        row_valid_d = 1'b1;
                        if (row_q == c_ROW_LAST) begin
                            row_last_d = 1'b1;
                            row_d      = '0;
                            state_d    = WAIT_SOF;
                        end else begin
                            row_d = row_q + c_ROW_W'(1);
                        end
                    end else begin
                        buf_we = 1'b1;
                        col_d  = col_q + c_COL_W'(1);
                    end
                end
            end
            default: begin
                state_d = WAIT_SOF;
            end
        endcase
    end

    // State, counters and status flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= WAIT_SOF;
            col_q       <= '0;
            row_q       <= '0;
            row_valid_q <= 1'b0;
            row_last_q  <= 1'b0;
            sof_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            row_q       <= row_d;
            row_valid_q <= row_valid_d;
            row_last_q  <= row_last_d;
            sof_err_q   <= sof_err_d;
        end
    end

    // Output row register: changes only when a full row completes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SIZE; i++) begin
                arr_q[i] <= '0;
            end
        end else if (arr_load) begin
            for (int i = 0; i < SIZE - 1; i++) begin
                arr_q[i] <= buf_rd[i];
            end
            arr_q[SIZE-1] <= pix_if.pix_in;
        end
    end

    assign arr_out   = arr_q;
    assign row_valid = row_valid_q;
    assign row_last  = row_last_q;
    assign sof_err   = sof_err_q;

endmodule : sobel_row_loader
`default_nettype wire

// File: tb/tb_sobel_row_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_sobel_row_loader
// Description : Directed self-checking bench for sobel_row_loader with
//               SIZE=4, ROWS=2.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sobel_row_loader;
    import sobel_pkg::*;

    localparam int SIZE = 4;
    localparam int ROWS = 2;

    logic   clk;
    logic   rst_n;
    pixel_t arr_out [SIZE-1:0];
    logic   row_valid;
    logic   row_last;
    logic   sof_err;

    int checks = 0;
    int errors = 0;
    int rv_cnt = 0;

    sobel_row_loader_if pif ();

    sobel_row_loader #(
        .SIZE (SIZE),
        .ROWS (ROWS)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .pix_if    (pif.slave),
        .arr_out   (arr_out),
        .row_valid (row_valid),
        .row_last  (row_last),
        .sof_err   (sof_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count every row_valid pulse, sampled on the falling edge.
    always @(negedge clk) begin
        if (row_valid === 1'b1) rv_cnt++;
    end

    function automatic logic [31:0] arr_word();
        return {arr_out[0], arr_out[1], arr_out[2], arr_out[3]};
    endfunction

    // One clock of stimulus; returns 1 time unit after the rising edge.
    task automatic step(input logic v, input logic s, input logic [7:0] p);
        @(negedge clk);
        pif.pix_valid = v;
        pif.pix_sof   = s;
        pif.pix_in    = p;
        @(posedge clk);
        #1;
        pif.pix_valid = 1'b0;
        pif.pix_sof   = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #2;
        checks++;
        if (pif.pix_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", pif.pix_ready); end
        checks++;
        if ({row_valid, row_last, sof_err} !== 3'b000) begin
            errors++; $display("FAIL reset_flags: got %b want 000", {row_valid, row_last, sof_err});
        end
        checks++;
        if (arr_word() !== 32'h0) begin errors++; $display("FAIL reset_arr: got %h want 00000000", arr_word()); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (pif.pix_ready !== 1'b1) begin errors++; $display("FAIL ready_after_reset: got %b want 1", pif.pix_ready); end
    endtask

    task automatic test_two_rows();
        int base;
        step(1, 1, 8'd10); step(1, 0, 8'd11); step(1, 0, 8'd12); step(1, 0, 8'd13);
        checks++;
        if ({row_valid, row_last} !== 2'b10) begin errors++; $display("FAIL row0_flags: got %b want 10", {row_valid, row_last}); end
        checks++;
        if (arr_word() !== 32'h0A0B0C0D) begin errors++; $display("FAIL row0_arr: got %h want 0a0b0c0d", arr_word()); end
        step(1, 0, 8'd20);
        checks++;
        if (row_valid !== 1'b0) begin errors++; $display("FAIL row0_pulse_width: got %b want 0", row_valid); end
        step(1, 0, 8'd21); step(1, 0, 8'd22); step(1, 0, 8'd23);
        checks++;
        if ({row_valid, row_last} !== 2'b11) begin errors++; $display("FAIL row1_flags: got %b want 11", {row_valid, row_last}); end
        checks++;
        if (arr_word() !== 32'h14151617) begin errors++; $display("FAIL row1_arr: got %h want 14151617", arr_word()); end
        step(0, 0, 8'd0);
        base = rv_cnt;
        // Back in WAIT_SOF: non-sof pixels must be dropped.
        for (int i = 0; i < 5; i++) step(1, 0, 8'(90 + i));
        step(0, 0, 8'd0);
        checks++;
        if (rv_cnt - base !== 0) begin errors++; $display("FAIL wait_sof_discard: got %0d pulses want 0", rv_cnt - base); end
        checks++;
        if (arr_word() !== 32'h14151617) begin errors++; $display("FAIL wait_sof_hold: got %h want 14151617", arr_word()); end
    endtask

    task automatic test_no_sof();
        int base;
        do_reset();
        base = rv_cnt;
        for (int i = 0; i < 5; i++) step(1, 0, 8'(1 + i));
        step(0, 0, 8'd0);
        checks++;
        if (rv_cnt - base !== 0) begin errors++; $display("FAIL no_sof_rows: got %0d pulses want 0", rv_cnt - base); end
        checks++;
        if (arr_word() !== 32'h0) begin errors++; $display("FAIL no_sof_arr: got %h want 00000000", arr_word()); end
    endtask

    task automatic test_sof_restart();
        int base;
        do_reset();
        base = rv_cnt;
        step(1, 1, 8'd1); step(1, 0, 8'd2);
        checks++;
        if (sof_err !== 1'b0) begin errors++; $display("FAIL sof_err_early: got %b want 0", sof_err); end
        step(1, 1, 8'd7);
        checks++;
        if (sof_err !== 1'b1) begin errors++; $display("FAIL sof_err_set: got %b want 1", sof_err); end
        step(1, 0, 8'd8); step(1, 0, 8'd9); step(1, 0, 8'd6);
        step(0, 0, 8'd0);
        checks++;
        if (rv_cnt - base !== 1) begin errors++; $display("FAIL restart_rows: got %0d pulses want 1", rv_cnt - base); end
        checks++;
        if (arr_word() !== 32'h07080906) begin errors++; $display("FAIL restart_arr: got %h want 07080906", arr_word()); end
        checks++;
        if (sof_err !== 1'b1) begin errors++; $display("FAIL sof_err_sticky: got %b want 1", sof_err); end
    endtask

    task automatic test_gaps();
        do_reset();
        step(1, 1, 8'd30); step(0, 0, 8'd0); step(1, 0, 8'd31);
        step(0, 1, 8'd0); step(0, 0, 8'd99); step(1, 0, 8'd32);
        checks++;
        if ({row_valid, arr_word()} !== 33'h0) begin
            errors++; $display("FAIL gap_partial: got valid=%b arr=%h want 0/00000000", row_valid, arr_word());
        end
        step(0, 0, 8'd0);
        step(1, 0, 8'd33);
        checks++;
        if (row_valid !== 1'b1 || arr_word() !== 32'h1E1F2021) begin
            errors++; $display("FAIL gap_row: got valid=%b arr=%h want 1/1e1f2021", row_valid, arr_word());
        end
        step(0, 0, 8'd0); step(0, 0, 8'd0);
        checks++;
        if (row_valid !== 1'b0 || arr_word() !== 32'h1E1F2021) begin
            errors++; $display("FAIL gap_hold: got valid=%b arr=%h want 0/1e1f2021", row_valid, arr_word());
        end
        // Restart on a row boundary: no error, row count restarts.
        step(1, 1, 8'd40); step(1, 0, 8'd41); step(1, 0, 8'd42); step(1, 0, 8'd43);
        checks++;
        if ({row_valid, row_last, sof_err} !== 3'b100) begin
            errors++; $display("FAIL boundary_sof_flags: got %b want 100", {row_valid, row_last, sof_err});
        end
        checks++;
        if (arr_word() !== 32'h28292A2B) begin errors++; $display("FAIL boundary_sof_arr: got %h want 28292a2b", arr_word()); end
    endtask

    task automatic test_reset_mid_row();
        int base;
        step(1, 0, 8'd50); step(1, 1, 8'd51); step(1, 0, 8'd52);
        // Asynchronous assertion between edges.
        rst_n = 1'b0;
        #2;
        checks++;
        if ({pif.pix_ready, row_valid, row_last, sof_err} !== 4'b0000 || arr_word() !== 32'h0) begin
            errors++;
            $display("FAIL mid_reset_outputs: got rdy/v/l/e=%b arr=%h want 0000/00000000",
                     {pif.pix_ready, row_valid, row_last, sof_err}, arr_word());
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        base = rv_cnt;
        step(1, 0, 8'd53);
        step(1, 1, 8'd60); step(1, 0, 8'd61); step(1, 0, 8'd62); step(1, 0, 8'd63);
        step(0, 0, 8'd0);
        checks++;
        if (rv_cnt - base !== 1) begin errors++; $display("FAIL post_reset_rows: got %0d pulses want 1", rv_cnt - base); end
        checks++;
        if (arr_word() !== 32'h3C3D3E3F || sof_err !== 1'b0) begin
            errors++; $display("FAIL post_reset_arr: got %h err=%b want 3c3d3e3f err=0", arr_word(), sof_err);
        end
    endtask

    task automatic test_sof_on_last();
        do_reset();
        step(1, 1, 8'd1); step(1, 0, 8'd2); step(1, 0, 8'd3); step(1, 1, 8'd70);
        checks++;
        if ({row_valid, sof_err} !== 2'b01) begin
            errors++; $display("FAIL sof_last_flags: got valid/err=%b want 01", {row_valid, sof_err});
        end
        step(1, 0, 8'd71); step(1, 0, 8'd72);
        checks++;
        if (row_valid !== 1'b0) begin errors++; $display("FAIL sof_last_early_row: got %b want 0", row_valid); end
        step(1, 0, 8'd73);
        checks++;
        if (row_valid !== 1'b1 || arr_word() !== 32'h46474849) begin
            errors++; $display("FAIL sof_last_row: got valid=%b arr=%h want 1/46474849", row_valid, arr_word());
        end
    endtask

    initial begin
        rst_n         = 1'b1;
        pif.pix_in    = '0;
        pif.pix_valid = 1'b0;
        pif.pix_sof   = 1'b0;
        test_reset();
        test_two_rows();
        test_no_sof();
        test_sof_restart();
        test_gaps();
        test_reset_mid_row();
        test_sof_on_last();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete within 200000 time units");
        $fatal(1);
    end

endmodule : tb_sobel_row_loader
`default_nettype wire
